// File: rtl/event_pkg.sv
// Shared state encoding and field layout for the event ack responder.
package event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_e;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 16;
  localparam int SEQ_LSB  = 16;
  localparam int SEQ_W    = 32;

  localparam int LEN_LSB  = 16;
  localparam int LEN_W    = 16;

endpackage

// File: rtl/event_ack_responder.sv
// Forwards one event's qwords per control word, then returns an ack/nack
// carrying {sequence, address} once the delivered length has been checked.
module event_ack_responder
  import event_pkg::*;
#(
  parameter string NACK_ON_MISMATCH = "TRUE",
  parameter string DEBUG            = "FALSE"
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_ev_ctrl_tdata,
  input  logic        s_ev_ctrl_tvalid,
  output logic        s_ev_ctrl_tready,
  input  logic [63:0] s_ev_data_tdata,
  input  logic [7:0]  s_ev_data_tkeep,
  input  logic        s_ev_data_tlast,
  input  logic        s_ev_data_tvalid,
  output logic        s_ev_data_tready,
  output logic [63:0] m_pkt_tdata,
  output logic [7:0]  m_pkt_tkeep,
  output logic        m_pkt_tlast,
  output logic        m_pkt_tvalid,
  input  logic        m_pkt_tready,
  output logic [47:0] m_ack_tdata,
  output logic        m_ack_tvalid,
  input  logic        m_ack_tready,
  output logic [47:0] m_nack_tdata,
  output logic        m_nack_tvalid,
  input  logic        m_nack_tready,
  output logic [31:0] event_count_o,
  output logic [15:0] mismatch_count_o,
  output logic        busy_o
);

  localparam bit NACK_EN = (NACK_ON_MISMATCH == "TRUE");

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [16:0]       r_exp;
  logic [16:0]       r_cnt;
  logic [16:0]       w_cnt_inc;
  logic              r_mis;
  logic              w_mis;
  logic              w_to_nack;
  logic              r_ack_vld;
  logic              r_nack_vld;
  logic [47:0]       r_resp;
  logic [31:0]       r_evcnt;
  logic [15:0]       r_miscnt;
  logic [LEN_W-1:0]  w_len;
  logic              w_ctrl_hs;
  logic              w_data_hs;
  logic              w_last_hs;
  logic              w_resp_hs;

  assign w_len     = s_ev_ctrl_tdata[LEN_LSB +: LEN_W];
  assign w_ctrl_hs = s_ev_ctrl_tvalid && s_ev_ctrl_tready;
  assign w_data_hs = s_ev_data_tvalid && s_ev_data_tready;
  assign w_last_hs = w_data_hs && s_ev_data_tlast;
  assign w_resp_hs = (r_ack_vld && m_ack_tready)
                  || (r_nack_vld && m_nack_tready);

  // Saturating count; the compare uses the count including this qword.
  assign w_cnt_inc = (r_cnt == 17'h1FFFF) ? r_cnt : r_cnt + 17'd1;
  assign w_mis     = (w_cnt_inc != r_exp);
  assign w_to_nack = w_mis && NACK_EN;

  assign m_pkt_tdata      = s_ev_data_tdata;
  assign m_pkt_tkeep      = s_ev_data_tkeep;
  assign m_pkt_tlast      = s_ev_data_tlast;
  assign m_ack_tdata      = r_resp;
  assign m_nack_tdata     = r_resp;
  assign m_ack_tvalid     = r_ack_vld;
  assign m_nack_tvalid    = r_nack_vld;
  assign event_count_o    = r_evcnt;
  assign mismatch_count_o = r_miscnt;
  assign busy_o           = (r_state != IDLE);

  always_comb begin
    w_state_nxt      = r_state;
    s_ev_ctrl_tready = 1'b0;
    s_ev_data_tready = 1'b0;
    m_pkt_tvalid     = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Held low in reset so no control word is lost to it.
        s_ev_ctrl_tready = aresetn;
        if (s_ev_ctrl_tvalid && aresetn) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        s_ev_data_tready = m_pkt_tready;
        m_pkt_tvalid     = s_ev_data_tvalid;
        if (s_ev_data_tvalid && m_pkt_tready && s_ev_data_tlast) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (w_resp_hs) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_exp      <= '0;
      r_cnt      <= '0;
      r_mis      <= 1'b0;
      r_ack_vld  <= 1'b0;
      r_nack_vld <= 1'b0;
      r_resp     <= '0;
      r_evcnt    <= '0;
      r_miscnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ctrl_hs) begin
        r_addr <= s_ev_ctrl_tdata[ADDR_LSB +: ADDR_W];
        r_exp  <= {(w_len == '0), w_len};
        r_cnt  <= '0;
      end
      if (w_data_hs) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_last_hs) begin
        r_mis                      <= w_mis;
        r_ack_vld                  <= !w_to_nack;
        r_nack_vld                 <= w_to_nack;
        r_resp[SEQ_LSB +: SEQ_W]   <= r_evcnt;
        r_resp[ADDR_LSB +: ADDR_W] <= r_addr;
      end
      if (w_resp_hs) begin
        r_ack_vld  <= 1'b0;
        r_nack_vld <= 1'b0;
        r_evcnt    <= r_evcnt + 32'd1;
        if (r_mis && (r_miscnt != 16'hFFFF)) begin
          r_miscnt <= r_miscnt + 16'd1;
        end
      end
    end
  end

  if (DEBUG == "TRUE") begin : g_debug
    state_e w_dbg_state;
    assign w_dbg_state = r_state;
  end

endmodule

// File: tb/tb_event_ack_responder.sv
// Bench for event_ack_responder: vector table, directed corners, random model.
module tb_event_ack_responder;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_ev_ctrl_tdata;
  logic        s_ev_ctrl_tvalid;
  logic        s_ev_ctrl_tready;
  logic [63:0] s_ev_data_tdata;
  logic [7:0]  s_ev_data_tkeep;
  logic        s_ev_data_tlast;
  logic        s_ev_data_tvalid;
  logic        s_ev_data_tready;
  logic [63:0] m_pkt_tdata;
  logic [7:0]  m_pkt_tkeep;
  logic        m_pkt_tlast;
  logic        m_pkt_tvalid;
  logic        m_pkt_tready;
  logic [47:0] m_ack_tdata;
  logic        m_ack_tvalid;
  logic        m_ack_tready;
  logic [47:0] m_nack_tdata;
  logic        m_nack_tvalid;
  logic        m_nack_tready;
  logic [31:0] event_count_o;
  logic [15:0] mismatch_count_o;
  logic        busy_o;

  logic        f_ctrl_tready;
  logic        f_data_tready;
  logic [63:0] f_pkt_tdata;
  logic [7:0]  f_pkt_tkeep;
  logic        f_pkt_tlast;
  logic        f_pkt_tvalid;
  logic [47:0] f_ack_tdata;
  logic        f_ack_tvalid;
  logic [47:0] f_nack_tdata;
  logic        f_nack_tvalid;
  logic [31:0] f_evcnt;
  logic [15:0] f_miscnt;
  logic        f_busy;

  always #5 aclk = ~aclk;

  event_ack_responder #(.NACK_ON_MISMATCH("TRUE")) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_ev_ctrl_tdata(s_ev_ctrl_tdata), .s_ev_ctrl_tvalid(s_ev_ctrl_tvalid),
    .s_ev_ctrl_tready(s_ev_ctrl_tready),
    .s_ev_data_tdata(s_ev_data_tdata), .s_ev_data_tkeep(s_ev_data_tkeep),
    .s_ev_data_tlast(s_ev_data_tlast), .s_ev_data_tvalid(s_ev_data_tvalid),
    .s_ev_data_tready(s_ev_data_tready),
    .m_pkt_tdata(m_pkt_tdata), .m_pkt_tkeep(m_pkt_tkeep),
    .m_pkt_tlast(m_pkt_tlast), .m_pkt_tvalid(m_pkt_tvalid),
    .m_pkt_tready(m_pkt_tready),
    .m_ack_tdata(m_ack_tdata), .m_ack_tvalid(m_ack_tvalid),
    .m_ack_tready(m_ack_tready),
    .m_nack_tdata(m_nack_tdata), .m_nack_tvalid(m_nack_tvalid),
    .m_nack_tready(m_nack_tready),
    .event_count_o(event_count_o), .mismatch_count_o(mismatch_count_o),
    .busy_o(busy_o)
  );

  event_ack_responder #(.NACK_ON_MISMATCH("FALSE")) dut_f (
    .aclk(aclk), .aresetn(aresetn),
    .s_ev_ctrl_tdata(s_ev_ctrl_tdata), .s_ev_ctrl_tvalid(s_ev_ctrl_tvalid),
    .s_ev_ctrl_tready(f_ctrl_tready),
    .s_ev_data_tdata(s_ev_data_tdata), .s_ev_data_tkeep(s_ev_data_tkeep),
    .s_ev_data_tlast(s_ev_data_tlast), .s_ev_data_tvalid(s_ev_data_tvalid),
    .s_ev_data_tready(f_data_tready),
    .m_pkt_tdata(f_pkt_tdata), .m_pkt_tkeep(f_pkt_tkeep),
    .m_pkt_tlast(f_pkt_tlast), .m_pkt_tvalid(f_pkt_tvalid),
    .m_pkt_tready(m_pkt_tready),
    .m_ack_tdata(f_ack_tdata), .m_ack_tvalid(f_ack_tvalid),
    .m_ack_tready(m_ack_tready),
    .m_nack_tdata(f_nack_tdata), .m_nack_tvalid(f_nack_tvalid),
    .m_nack_tready(m_nack_tready),
    .event_count_o(f_evcnt), .mismatch_count_o(f_miscnt),
    .busy_o(f_busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [79:0] act,
                     input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn          = 1'b0;
    s_ev_ctrl_tvalid = 1'b0;
    s_ev_ctrl_tdata  = '0;
    s_ev_data_tvalid = 1'b0;
    s_ev_data_tdata  = '0;
    s_ev_data_tkeep  = '0;
    s_ev_data_tlast  = 1'b0;
    m_pkt_tready     = 1'b1;
    m_ack_tready     = 1'b1;
    m_nack_tready    = 1'b1;
    step();
    step();
    aresetn = 1'b1;
  endtask

  task automatic send_ctrl(input logic [31:0] w);
    int n = 0;
    s_ev_ctrl_tdata  = w;
    s_ev_ctrl_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_ev_ctrl_tready && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    chk("ctrl_accept", s_ev_ctrl_tready, 1);
    step();
    s_ev_ctrl_tvalid = 1'b0;
  endtask

  task automatic send_q(input logic [63:0] d, input logic [7:0] k,
                        input logic l);
    int n = 0;
    s_ev_data_tdata  = d;
    s_ev_data_tkeep  = k;
    s_ev_data_tlast  = l;
    s_ev_data_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_ev_data_tready && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    chk("data_accept", s_ev_data_tready, 1);
    step();
    s_ev_data_tvalid = 1'b0;
  endtask

  // Reference model for the random phase: every generated qword must come
  // out in order, and each event yields one ack of {sequence, address}.
  logic [72:0] q_pkt[$];
  logic [47:0] q_ack[$];
  bit          mon_en = 1'b0;
  bit          rnd_on = 1'b0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [47:0] prev_d = '0;

  initial forever begin
    @(negedge aclk);
    if (mon_en) begin
      chk("ack_nack_excl", m_ack_tvalid & m_nack_tvalid, 0);
      chk("rand_no_nack", m_nack_tvalid, 0);
      if (prev_v && !prev_r)
        chk("ack_hold", {m_ack_tvalid, m_ack_tdata}, {1'b1, prev_d});
      if (m_pkt_tvalid && m_pkt_tready) begin
        if (q_pkt.size() == 0) chk("pkt_extra", m_pkt_tvalid, 0);
        else chk("pkt_qword", {m_pkt_tlast, m_pkt_tkeep, m_pkt_tdata},
                 q_pkt.pop_front());
      end
      if (m_ack_tvalid && m_ack_tready) begin
        if (q_ack.size() == 0) chk("ack_extra", m_ack_tvalid, 0);
        else chk("ack_data", m_ack_tdata, q_ack.pop_front());
      end
      prev_v = m_ack_tvalid;
      prev_r = m_ack_tready;
      prev_d = m_ack_tdata;
    end else begin
      prev_v = 1'b0;
    end
  end

  initial forever begin
    @(posedge aclk);
    #1;
    if (rnd_on) begin
      m_pkt_tready  = 1'($urandom % 2);
      m_ack_tready  = 1'($urandom % 2);
      m_nack_tready = 1'($urandom % 2);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        v;
    logic        pr;
    logic        exp_pv;
    logic        exp_dr;
  } vec_t;

  vec_t        tv[6];
  logic [63:0] rd[64];
  logic [7:0]  rk[64];
  int          len;
  int          seq;
  logic [15:0] addr;

  initial begin
    tv[0] = '{64'hA0A0_0000_0000_0001, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tv[1] = '{64'h0,                   8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[2] = '{64'hA1A1_0000_0000_0002, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[3] = '{64'hA1A1_0000_0000_0002, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tv[4] = '{64'hA2A2_0000_0000_0003, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tv[5] = '{64'hA3A3_0000_0000_0004, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset values
    do_reset();
    @(negedge aclk);
    chk("rst_ctrl_rdy", s_ev_ctrl_tready, 1);
    chk("rst_data_rdy", s_ev_data_tready, 0);
    chk("rst_valids", {m_pkt_tvalid, m_ack_tvalid, m_nack_tvalid}, 0);
    chk("rst_counts", {event_count_o, mismatch_count_o, busy_o}, 0);
    chk("rst_f", {f_ctrl_tready, f_data_tready, f_busy, f_evcnt}, 80'h4_0000_0000);

    // Event of 4 qwords with stalls; pass-through checked per vector
    step();
    send_ctrl(32'h0004_1234);
    for (int i = 0; i < 6; i++) begin
      s_ev_data_tdata  = tv[i].d;
      s_ev_data_tkeep  = tv[i].k;
      s_ev_data_tlast  = tv[i].l;
      s_ev_data_tvalid = tv[i].v;
      m_pkt_tready     = tv[i].pr;
      @(negedge aclk);
      chk("t1_pkt_valid", m_pkt_tvalid, tv[i].exp_pv);
      chk("t1_data_rdy", s_ev_data_tready, tv[i].exp_dr);
      chk("t1_f_pkt_valid", f_pkt_tvalid, tv[i].exp_pv);
      if (tv[i].v) begin
        chk("t1_pkt_word", {m_pkt_tlast, m_pkt_tkeep, m_pkt_tdata},
            {tv[i].l, tv[i].k, tv[i].d});
        chk("t1_f_pkt_word", {f_pkt_tlast, f_pkt_tkeep, f_pkt_tdata},
            {tv[i].l, tv[i].k, tv[i].d});
      end
      step();
    end
    s_ev_data_tvalid = 1'b0;
    m_pkt_tready     = 1'b1;
    @(negedge aclk);
    chk("t1_ack_valid", {m_ack_tvalid, m_nack_tvalid}, 2'b10);
    chk("t1_ack_data", m_ack_tdata, 48'h0000_0000_1234);
    chk("t1_busy_resp", busy_o, 1);
    step();
    @(negedge aclk);
    chk("t1_evcnt", event_count_o, 1);
    chk("t1_idle", {busy_o, m_ack_tvalid, mismatch_count_o}, 0);

    // Short event: nack, or ack when nack is disabled
    do_reset();
    send_ctrl(32'h0004_0100);
    send_q(64'h1, 8'hFF, 1'b0);
    send_q(64'h2, 8'hFF, 1'b0);
    send_q(64'h3, 8'hFF, 1'b1);
    @(negedge aclk);
    chk("t2_nack_valid", {m_ack_tvalid, m_nack_tvalid}, 2'b01);
    chk("t2_nack_data", m_nack_tdata, 48'h0000_0000_0100);
    chk("t3_f_ack_valid", {f_ack_tvalid, f_nack_tvalid}, 2'b10);
    chk("t3_f_ack_data", f_ack_tdata, 48'h0000_0000_0100);
    step();
    @(negedge aclk);
    chk("t2_miscnt", mismatch_count_o, 1);
    chk("t2_evcnt", event_count_o, 1);
    chk("t3_f_miscnt", f_miscnt, 1);
    chk("t3_f_evcnt", f_evcnt, 1);
    chk("t2_nack_clr", {m_nack_tvalid, f_ack_tvalid, f_nack_tdata[15:0]},
        17'h0_0100);

    // Random traffic against the reference model
    do_reset();
    seq    = 0;
    mon_en = 1'b1;
    rnd_on = 1'b1;
    for (int e = 0; e < 100; e++) begin
      len  = $urandom_range(1, 64);
      addr = 16'($urandom);
      for (int i = 0; i < len; i++) begin
        rd[i] = {$urandom, $urandom};
        rk[i] = 8'($urandom);
        q_pkt.push_back({(i == len - 1), rk[i], rd[i]});
      end
      q_ack.push_back({seq[31:0], addr});
      seq++;
      send_ctrl({len[15:0], addr});
      for (int i = 0; i < len; i++) begin
        if ($urandom % 4 == 0) step();
        send_q(rd[i], rk[i], (i == len - 1));
      end
    end
    for (int i = 0; i < 3000 && q_ack.size() != 0; i++) @(negedge aclk);
    chk("rand_drain", q_ack.size() + q_pkt.size(), 0);
    rnd_on        = 1'b0;
    m_pkt_tready  = 1'b1;
    m_ack_tready  = 1'b1;
    m_nack_tready = 1'b1;
    step();
    step();
    mon_en = 1'b0;
    @(negedge aclk);
    chk("rand_evcnt", event_count_o, 100);
    chk("rand_miscnt", mismatch_count_o, 0);

    // Control word queued behind an event in flight
    do_reset();
    send_ctrl(32'h0002_0AAA);
    s_ev_ctrl_tdata  = 32'h0001_0BBB;
    s_ev_ctrl_tvalid = 1'b1;
    m_ack_tready     = 1'b0;
    @(negedge aclk);
    chk("t5_wait_data", s_ev_ctrl_tready, 0);
    step();
    send_q(64'h55, 8'hFF, 1'b0);
    send_q(64'h66, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("t5_wait_resp", s_ev_ctrl_tready, 0);
      chk("t5_ack_held", {m_ack_tvalid, m_ack_tdata}, {1'b1, 48'h0000_0000_0AAA});
      step();
    end
    m_ack_tready = 1'b1;
    @(negedge aclk);
    chk("t5_wait_hs", s_ev_ctrl_tready, 0);
    step();
    @(negedge aclk);
    chk("t5_idle_rdy", {s_ev_ctrl_tready, busy_o, m_ack_tvalid}, 3'b100);
    chk("t5_evcnt", event_count_o, 1);
    step();
    s_ev_ctrl_tvalid = 1'b0;
    @(negedge aclk);
    chk("t5_accepted", {busy_o, s_ev_ctrl_tready}, 2'b10);
    step();
    send_q(64'h77, 8'hFF, 1'b1);
    @(negedge aclk);
    chk("t5_ack2", {m_ack_tvalid, m_ack_tdata}, {1'b1, 48'h0000_0001_0BBB});
    step();
    @(negedge aclk);
    chk("t5_evcnt2", event_count_o, 2);

    // Reset in the middle of an event
    step();
    send_ctrl(32'h0008_0CCC);
    send_q(64'h10, 8'hFF, 1'b0);
    send_q(64'h11, 8'hFF, 1'b0);
    s_ev_data_tdata  = 64'h12;
    s_ev_data_tvalid = 1'b1;
    aresetn          = 1'b0;
    step();
    @(negedge aclk);
    chk("t6_in_rst", {m_ack_tvalid, m_nack_tvalid, busy_o, s_ev_data_tready,
                      m_pkt_tvalid}, 0);
    chk("t6_cnt_rst", event_count_o, 0);
    step();
    s_ev_data_tvalid = 1'b0;
    aresetn          = 1'b1;
    @(negedge aclk);
    chk("t6_rel_rdy", {s_ev_ctrl_tready, s_ev_data_tready}, 2'b10);
    chk("t6_rel_state", {busy_o, m_ack_tvalid, m_nack_tvalid, mismatch_count_o},
        0);
    step();
    send_ctrl(32'h0001_0DDD);
    send_q(64'h99, 8'h0F, 1'b1);
    @(negedge aclk);
    chk("t6_ack", {m_ack_tvalid, m_ack_tdata}, {1'b1, 48'h0000_0000_0DDD});
    step();
    @(negedge aclk);
    chk("t6_evcnt", event_count_o, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
